// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - VGA read port between the memory interface and the frame reader
interface vga_frame_reader_if #(
  parameter int MEM_WIDTH = 36
);
  logic                 vga_flag;
  logic                 done_vga;
  logic [MEM_WIDTH-1:0] vga_pixel;

  modport master (
    output vga_flag,
    input  done_vga,
    input  vga_pixel
  );

  modport slave (
    input  vga_flag,
    output done_vga,
    output vga_pixel
  );
endinterface

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - prefetches two-pixel words into a small FIFO and unpacks one pixel per pixel_req
module vga_frame_reader #(
  parameter int MEM_WIDTH    = 36,
  parameter int PIX_WIDTH    = 18,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_req,
  vga_frame_reader_if.master    mem,
  output logic [PIX_WIDTH-1:0]  pixel_out,
  output logic                  pixel_valid,
  output logic                  underflow
);

  localparam int WORDS_PER_FRAME = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W  = $clog2(READ_LATENCY + 1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  logic [WCNT_W-1:0]       word_cnt_q, word_cnt_d;
  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]       fifo_count_q, fifo_count_d;
  logic                    half_q, half_d;
  logic [PIX_WIDTH-1:0]    pixel_out_q, pixel_out_d;
  logic                    pixel_valid_q, pixel_valid_d;
  logic                    underflow_q, underflow_d;

  logic [MEM_WIDTH-1:0]    fifo_mem_q [FIFO_DEPTH];

  logic [INF_W-1:0]        inflight_cnt;
  logic                    level_ok;
  logic                    vga_flag;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    has_word;
  logic [MEM_WIDTH-1:0]    head_word;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + INF_W'(inflight_q[i]);
    end
  end

  // Reads still in flight reserve FIFO space, so a returning word always has a slot.
  assign level_ok  = (LVL_W'(fifo_count_q) + LVL_W'(inflight_cnt)) < LVL_W'(FIFO_DEPTH);
  assign vga_flag  = !reset && !frame_start
                     && (word_cnt_q < WCNT_W'(WORDS_PER_FRAME)) && level_ok;
  assign mem.vga_flag = vga_flag;

  assign accept    = vga_flag && mem.done_vga;
  assign push      = inflight_q[READ_LATENCY-1];
  assign has_word  = (fifo_count_q != '0);
  assign head_word = fifo_mem_q[rd_ptr_q];

  always_comb begin
    word_cnt_d    = word_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    half_d        = half_q;
    pixel_out_d   = pixel_out_q;
    pixel_valid_d = 1'b0;
    underflow_d   = underflow_q;
    pop           = 1'b0;

    inflight_d[0] = accept;
    for (int i = 1; i < READ_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end

    if (accept) begin
      word_cnt_d = word_cnt_q + WCNT_W'(1);
    end

    // half_q = 0 selects the upper (even-x) pixel; the word leaves after its lower half.
    if (pixel_req) begin
      if (has_word) begin
        pixel_out_d   = half_q ? head_word[PIX_WIDTH-1:0]
                               : head_word[MEM_WIDTH-1:PIX_WIDTH];
        pixel_valid_d = 1'b1;
        half_d        = !half_q;
        pop           = half_q;
      end else begin
        pixel_out_d   = '0;
        underflow_d   = 1'b1;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + FCNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - FCNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    // Frame restart drops buffered and in-flight words; the last pixel stays on the output.
    if (frame_start) begin
      word_cnt_d    = '0;
      inflight_d    = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fifo_count_d  = '0;
      half_d        = 1'b0;
      underflow_d   = 1'b0;
      pixel_valid_d = 1'b0;
      pixel_out_d   = pixel_out_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt_q    <= '0;
      inflight_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      half_q        <= 1'b0;
      pixel_out_q   <= '0;
      pixel_valid_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      inflight_q    <= inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      half_q        <= half_d;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= pixel_valid_d;
      underflow_q   <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= mem.vga_pixel;
    end
  end

  assign pixel_out   = pixel_out_q;
  assign pixel_valid = pixel_valid_q;
  assign underflow   = underflow_q;

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Display-side consumer of the memory interface's VGA read port. Prefetches packed two-pixel words from the display frame buffer using the vga_flag/done_vga handshake and absorbs the fixed read latency in a small word FIFO. Unpacks each word into two pixels and delivers one pixel per pixel_req strobe from the VGA timing generator. Sits between the memory interface and the VGA output/DAC stage.

Parameters:
MEM_WIDTH, 36, width of one SRAM word (two pixels)
PIX_WIDTH, 18, width of one pixel (MEM_WIDTH/2)
IMAGE_WIDTH, 640, pixels per line
IMAGE_HEIGHT, 480, lines per frame
READ_LATENCY, 2, cycles from accepted request (done_vga high) to valid vga_pixel
FIFO_DEPTH, 8, word FIFO entries (power of two)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of frame; same pulse as the memory interface's frame_flag
pixel_req  in  1  timing generator consumes one pixel this cycle
vga_flag  out  1  read request to the memory interface
done_vga  in  1  request accepted this cycle, same cycle as vga_flag
vga_pixel  in  MEM_WIDTH  read data; valid exactly READ_LATENCY cycles after done_vga
pixel_out  out  PIX_WIDTH  current pixel
pixel_valid  out  1  pixel_out holds a real pixel for the last pixel_req
underflow  out  1  sticky: pixel_req seen with no pixel available this frame

Behaviour:
- Reset values: vga_flag 0, pixel_out 0, pixel_valid 0, underflow 0. FIFO empty, in-flight empty, word counter 0, half select = upper.
- WORDS_PER_FRAME = IMAGE_WIDTH*IMAGE_HEIGHT/2. word_cnt counts accepted requests (done_vga & vga_flag); width ceil(log2(WORDS_PER_FRAME+1)).
- In-flight tracker: READ_LATENCY-stage shift register of valid bits. Stage 0 loads (vga_flag & done_vga & !frame_start). When the last stage is 1, vga_pixel is pushed into the FIFO. inflight = popcount of the stages.
- vga_flag is combinational: !reset & !frame_start & (word_cnt < WORDS_PER_FRAME) & (fifo_count + inflight < FIFO_DEPTH). Counting in-flight reads guarantees a push never meets a full FIFO. If done_vga stays low because arbitration was lost, vga_flag holds and the request is retried. There is no timeout.
- done_vga without vga_flag is ignored.
- Unpack order: upper half [MEM_WIDTH-1:PIX_WIDTH] = even x, output first. Lower half = odd x. The word is popped from the FIFO after its lower half is output.
- Output latency 1: a pixel_req in cycle N yields pixel_out/pixel_valid in cycle N+1. On a cycle with no pixel_req, pixel_out holds its last value and pixel_valid = 0.
- Empty on pixel_req: pixel_out = 0, pixel_valid = 1'b0, underflow set. The half select does not advance. underflow clears only on frame_start or reset.
- Push and pop in the same cycle: allowed, and fifo_count is unchanged.
- frame_start (highest priority after reset):
  - flush FIFO, clear all in-flight stages (data arriving later is dropped), word_cnt = 0, half select = upper, underflow = 0.
  - A pixel_req in the same cycle is ignored (pixel_valid 0 next cycle).
  - A done_vga in the same cycle is not counted, because the memory interface restarts its address on that edge.
  - Requesting resumes in the cycle after frame_start.
- Frame end: once word_cnt = WORDS_PER_FRAME, vga_flag stays 0 until frame_start. Extra pixel_req after the last pixel follow the empty rule.
- Reset mid-frame behaves identically to frame_start, and additionally clears pixel_out.

Test Plan:
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, done_vga tied to vga_flag, memory model returns word n = {18'(2n), 18'(2n+1)} with latency 2; frame_start, then pixel_req every cycle from cycle 10 -> pixel_out sequence 0..7 with pixel_valid 1, exactly 4 accepted requests, underflow 0.
- FIFO_DEPTH=8, no pixel_req, done_vga always 1 -> exactly 8 accepted requests, then vga_flag stays 0. One pixel_req pair -> exactly one new request is issued.
- done_vga low for 5 cycles while vga_flag is high -> vga_flag stays high, word_cnt unchanged, and the word order is correct after acceptance.
- pixel_req on an empty FIFO after reset -> next cycle pixel_out = 0, pixel_valid = 0, underflow = 1 and stays 1 until frame_start.
- frame_start asserted one cycle after done_vga, with 2 words in flight -> both in-flight words are dropped, fifo_count = 0, and the first pixel after restart is word 0's upper half.
- frame_start coincident with done_vga and pixel_req -> request not counted, pixel_valid 0 next cycle, vga_flag 0 that cycle and 1 the cycle after.
